layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Network-level controller; sits directly upstream of LayerParaScaleFloat16.
//  Turns a level start into a walk over the fixed 5-layer CNN (prepare, conv, conv, pool, fc).
//  For each layer it drives layer_num, layer_type, pre_layer_type and the full per-layer
//  configuration bus, then waits on layer_ready before advancing.
//  Also reports network completion and a per-layer cycle count for bring-up.
// PARAMETERS
//  LAYER_COUNT        5   layers walked, numbered 0..LAYER_COUNT-1
//  CYCLE_CNT_WIDTH    32  width of the per-layer cycle counter
//  Field widths (LAYER_NUM_WIDTH=3, FM_SIZE_WIDTH, KERNEL_SIZE_WIDTH, KERNEL_NUM_WIDTH,
//  PADDING_NUM_WIDTH, POOL_SIZE_WIDTH) come from the shared defines, not parameters.
// PORTS
//  clk                 in   1    single system clock, rising edge
//  rst                 in   1    asynchronous, active-low reset
//  transmission_start  in   1    level; rising edge starts a run, low aborts
//  layer_ready         in   1    level from LayerParaScaleFloat16: current layer finished
//  layer_start         out  1    1-cycle pulse: config valid, layer may begin
//  layer_num           out  3    current layer index
//  layer_type          out  2    0 prepare, 1 conv, 2 pool, 3 fc
//  pre_layer_type      out  2    layer_type of the previous layer; 0 for layer 0
//  fm_size             out  FSW  input map size
//  fm_depth            out  KSW  input map depth
//  fm_size_out         out  FSW  output map size, padding included
//  padding_out         out  PNW  padding applied to the output
//  kernel_num          out  KNW  output depth
//  kernel_size         out  KSW  kernel size
//  pool_type           out  1    0 max, 1 avg
//  pool_win_size       out  PSW  pool window
//  activation          out  2    0 none, 1 ReLU
//  busy                out  1    high in every state except IDLE
//  net_done            out  1    1-cycle pulse after the last layer's ready
//  layer_cycles        out  CCW  cycles spent in RUN by the last completed layer
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; edge-detect register 0.
//  States:
//   - IDLE: a rising edge of transmission_start (1 now, 0 last cycle) -> LOAD with layer_num=0.
//   - LOAD: for 1 cycle, registers the table row for layer_num onto the config outputs -> RUN.
//   - RUN: layer_start=1 on the first RUN cycle only.
//       layer_ready is ignored on that cycle; any later cycle with ready=1 -> ADV.
//       The counter starts at 0 on entry, +1 per RUN cycle, saturates at all-ones.
//   - ADV: layer_cycles <= counter; pre_layer_type <= layer_type.
//       If layer_num==LAYER_COUNT-1 -> DONE; else layer_num+1 -> LOAD.
//   - DONE: net_done=1 for 1 cycle -> IDLE. layer_num and config hold until the next start.
//  Latency: start edge -> layer_start is 2 cycles; ready -> next layer_start is 3 cycles.
//  Abort: transmission_start=0 in LOAD/RUN/ADV -> IDLE next cycle.
//   Abort clears layer_num, pre_layer_type and layer_start; config holds; no net_done.
//   Abort takes priority over a simultaneous layer_ready.
//  transmission_start held high after DONE does not restart; a fresh rising edge is required.
//  Config table (type, fm_size, fm_depth, fm_size_out, padding_out, kernel_num,
//   kernel_size, pool_type, pool_win, activation):
//   L0: 0, 28, 1,  28, 0, 1,  1,  0, 0, 0
//   L1: 1, 28, 1,  24, 0, 8,  5,  0, 0, 1
//   L2: 1, 24, 8,  22, 0, 16, 3,  0, 0, 1
//   L3: 2, 22, 16, 11, 0, 16, 0,  0, 2, 0
//   L4: 3, 11, 16, 1,  0, 10, 11, 0, 0, 0
//   Any other layer_num decodes to all zeros.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared package/defines: layer_type codes, state encoding, field widths, LAYER_COUNT.
//  One sub-module: layer_config_rom. It is a combinational table lookup on layer_num
//   and returns the packed config; the sequencer registers it in LOAD.
// TESTING
//  1. Reset mid-RUN (rst=0 for 1 cycle) -> all outputs 0 within the same cycle;
//     busy=0; layer_num=0.
//  2. Rise transmission_start, answer each layer_start with ready after 10 cycles ->
//     layer_num 0..4, types 0,1,1,2,3; layer_cycles=10 each; net_done once; busy low after.
//  3. Hold layer_ready=1 throughout -> ready ignored on each layer_start cycle;
//     every layer reports layer_cycles=1; pre_layer_type sequence 0,0,1,1,2.
//  4. Drop transmission_start during the L2 RUN, same cycle as ready -> IDLE;
//     layer_num=0; no net_done; next rising edge restarts at L0.
//  5. Keep start high after net_done -> no new layer_start;
//     toggle start low then high -> new run begins 2 cycles after the edge.
//  6. Check L3 config registers exactly: fm_size=22, fm_depth=16, fm_size_out=11,
//     pool_win_size=2, activation=0.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the network layer sequencer: field widths,
// layer type codes, FSM encoding and the packed per-layer config record.
package layer_sequencer_pkg;

  localparam int DEF_LAYER_COUNT   = 5;
  localparam int LAYER_NUM_WIDTH   = 3;
  localparam int FM_SIZE_WIDTH     = 8;
  localparam int KERNEL_SIZE_WIDTH = 8;
  localparam int KERNEL_NUM_WIDTH  = 8;
  localparam int PADDING_NUM_WIDTH = 4;
  localparam int POOL_SIZE_WIDTH   = 4;

  localparam logic [1:0] LT_PREPARE = 2'd0;
  localparam logic [1:0] LT_CONV    = 2'd1;
  localparam logic [1:0] LT_POOL    = 2'd2;
  localparam logic [1:0] LT_FC      = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_ADV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef struct packed {
    logic [1:0]                   layer_type;
    logic [FM_SIZE_WIDTH-1:0]     fm_size;
    logic [KERNEL_SIZE_WIDTH-1:0] fm_depth;
    logic [FM_SIZE_WIDTH-1:0]     fm_size_out;
    logic [PADDING_NUM_WIDTH-1:0] padding_out;
    logic [KERNEL_NUM_WIDTH-1:0]  kernel_num;
    logic [KERNEL_SIZE_WIDTH-1:0] kernel_size;
    logic                         pool_type;
    logic [POOL_SIZE_WIDTH-1:0]   pool_win_size;
    logic [1:0]                   activation;
  } layer_cfg_t;

  // Builds one table row from plain integers so the ROM reads like the table.
  function automatic layer_cfg_t mk_cfg(input logic [1:0] lt, input int fs, input int fd,
                                        input int fo, input int pad, input int kn,
                                        input int ks, input int pt, input int pw,
                                        input int act);
    layer_cfg_t c;
    c.layer_type    = lt;
    c.fm_size       = FM_SIZE_WIDTH'(fs);
    c.fm_depth      = KERNEL_SIZE_WIDTH'(fd);
    c.fm_size_out   = FM_SIZE_WIDTH'(fo);
    c.padding_out   = PADDING_NUM_WIDTH'(pad);
    c.kernel_num    = KERNEL_NUM_WIDTH'(kn);
    c.kernel_size   = KERNEL_SIZE_WIDTH'(ks);
    c.pool_type     = 1'(pt);
    c.pool_win_size = POOL_SIZE_WIDTH'(pw);
    c.activation    = 2'(act);
    return c;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/config bus between the sequencer and LayerParaScaleFloat16.
interface layer_sequencer_if #(parameter int CCW = 32);
  import layer_sequencer_pkg::*;

  logic                         transmission_start;
  logic                         layer_ready;
  logic                         layer_start;
  logic [LAYER_NUM_WIDTH-1:0]   layer_num;
  logic [1:0]                   layer_type;
  logic [1:0]                   pre_layer_type;
  logic [FM_SIZE_WIDTH-1:0]     fm_size;
  logic [KERNEL_SIZE_WIDTH-1:0] fm_depth;
  logic [FM_SIZE_WIDTH-1:0]     fm_size_out;
  logic [PADDING_NUM_WIDTH-1:0] padding_out;
  logic [KERNEL_NUM_WIDTH-1:0]  kernel_num;
  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size;
  logic                         pool_type;
  logic [POOL_SIZE_WIDTH-1:0]   pool_win_size;
  logic [1:0]                   activation;
  logic                         busy;
  logic                         net_done;
  logic [CCW-1:0]               layer_cycles;

  modport master (
    input  transmission_start, layer_ready,
    output layer_start, layer_num, layer_type, pre_layer_type, fm_size, fm_depth,
           fm_size_out, padding_out, kernel_num, kernel_size, pool_type,
           pool_win_size, activation, busy, net_done, layer_cycles
  );

  modport slave (
    output transmission_start, layer_ready,
    input  layer_start, layer_num, layer_type, pre_layer_type, fm_size, fm_depth,
           fm_size_out, padding_out, kernel_num, kernel_size, pool_type,
           pool_win_size, activation, busy, net_done, layer_cycles
  );
endinterface

// File: rtl/layer_sequencer_config_rom.sv
// Fixed 5-layer CNN configuration table, indexed by layer number.
module layer_config_rom
  import layer_sequencer_pkg::*;
(
  input  logic [LAYER_NUM_WIDTH-1:0] layer_num,
  output layer_cfg_t                 cfg
);

  // Pure lookup; unlisted indices decode to an all-zero row.
  always_comb begin
    cfg = '0;
    case (layer_num)
      3'd0: cfg = mk_cfg(LT_PREPARE, 28, 1, 28, 0, 1, 1, 0, 0, 0);
      3'd1: cfg = mk_cfg(LT_CONV,    28, 1, 24, 0, 8, 5, 0, 0, 1);
      3'd2: cfg = mk_cfg(LT_CONV,    24, 8, 22, 0, 16, 3, 0, 0, 1);
      3'd3: cfg = mk_cfg(LT_POOL,    22, 16, 11, 0, 16, 0, 0, 2, 0);
      3'd4: cfg = mk_cfg(LT_FC,      11, 16, 1, 0, 10, 11, 0, 0, 0);
      default: cfg = '0;
    endcase
  end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the fixed CNN layer by layer: loads each layer's config, pulses
// layer_start, waits for layer_ready, and reports per-layer cycle counts.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int LAYER_COUNT     = DEF_LAYER_COUNT,
  parameter int CYCLE_CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  bus
);

  logic [2:0]                 state_q, state_d;
  logic                       ts_prev_q;
  logic [LAYER_NUM_WIDTH-1:0] layer_num_q, layer_num_d;
  layer_cfg_t                 cfg_q, cfg_d, rom_cfg;
  logic [1:0]                 pre_type_q, pre_type_d;
  logic                       layer_start_q, layer_start_d;
  logic                       busy_q, busy_d;
  logic                       net_done_q, net_done_d;
  logic [CYCLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CYCLE_CNT_WIDTH-1:0] layer_cycles_q, layer_cycles_d;
  logic                       abort;

  layer_config_rom u_rom (
    .layer_num (layer_num_q),
    .cfg       (rom_cfg)
  );

  assign abort = !bus.transmission_start;

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d        = state_q;
    layer_num_d    = layer_num_q;
    cfg_d          = cfg_q;
    pre_type_d     = pre_type_q;
    cnt_d          = cnt_q;
    layer_cycles_d = layer_cycles_q;
    layer_start_d  = 1'b0;
    net_done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a fresh rising edge starts a run; a level left high does not.
        if (bus.transmission_start && !ts_prev_q) begin
          state_d     = ST_LOAD;
          layer_num_d = '0;
          pre_type_d  = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          layer_num_d = '0;
          pre_type_d  = '0;
        end else begin
          cfg_d         = rom_cfg;
          cnt_d         = '0;
          layer_start_d = 1'b1;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        // layer_start_q marks the first RUN cycle, where ready is stale.
        if (abort) begin
          state_d     = ST_IDLE;
          layer_num_d = '0;
          pre_type_d  = '0;
        end else if (bus.layer_ready && !layer_start_q) begin
          state_d = ST_ADV;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ADV: begin
        if (abort) begin
          state_d     = ST_IDLE;
          layer_num_d = '0;
          pre_type_d  = '0;
        end else begin
          layer_cycles_d = cnt_q;
          pre_type_d     = cfg_q.layer_type;
          if (layer_num_q == LAYER_NUM_WIDTH'(LAYER_COUNT - 1)) begin
            state_d    = ST_DONE;
            net_done_d = 1'b1;
          end else begin
            layer_num_d = layer_num_q + 1'b1;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      ts_prev_q      <= 1'b0;
      layer_num_q    <= '0;
      cfg_q          <= '0;
      pre_type_q     <= '0;
      layer_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      net_done_q     <= 1'b0;
      cnt_q          <= '0;
      layer_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ts_prev_q      <= bus.transmission_start;
      layer_num_q    <= layer_num_d;
      cfg_q          <= cfg_d;
      pre_type_q     <= pre_type_d;
      layer_start_q  <= layer_start_d;
      busy_q         <= busy_d;
      net_done_q     <= net_done_d;
      cnt_q          <= cnt_d;
      layer_cycles_q <= layer_cycles_d;
    end
  end

  assign bus.layer_start    = layer_start_q;
  assign bus.layer_num      = layer_num_q;
  assign bus.layer_type     = cfg_q.layer_type;
  assign bus.pre_layer_type = pre_type_q;
  assign bus.fm_size        = cfg_q.fm_size;
  assign bus.fm_depth       = cfg_q.fm_depth;
  assign bus.fm_size_out    = cfg_q.fm_size_out;
  assign bus.padding_out    = cfg_q.padding_out;
  assign bus.kernel_num     = cfg_q.kernel_num;
  assign bus.kernel_size    = cfg_q.kernel_size;
  assign bus.pool_type      = cfg_q.pool_type;
  assign bus.pool_win_size  = cfg_q.pool_win_size;
  assign bus.activation     = cfg_q.activation;
  assign bus.busy           = busy_q;
  assign bus.net_done       = net_done_q;
  assign bus.layer_cycles   = layer_cycles_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios plus random ready delays,
// holds and aborts, checked against a table-driven reference model.
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;

  typedef int dly_t [5];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_sequencer_if bus();

  layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference network description.
  int t_type [5] = '{0, 1, 1, 2, 3};
  int t_fm   [5] = '{28, 28, 24, 22, 11};
  int t_dep  [5] = '{1, 1, 8, 16, 16};
  int t_fout [5] = '{28, 24, 22, 11, 1};
  int t_kn   [5] = '{1, 8, 16, 16, 10};
  int t_ks   [5] = '{1, 5, 3, 0, 11};
  int t_pw   [5] = '{0, 0, 0, 2, 0};
  int t_act  [5] = '{0, 1, 1, 0, 0};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"},  bus.layer_start, 0);
    chk({tag, "_num"},    bus.layer_num, 0);
    chk({tag, "_type"},   bus.layer_type, 0);
    chk({tag, "_pre"},    bus.pre_layer_type, 0);
    chk({tag, "_fm"},     bus.fm_size, 0);
    chk({tag, "_kn"},     bus.kernel_num, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_done"},   bus.net_done, 0);
    chk({tag, "_cycles"}, bus.layer_cycles, 0);
  endtask

  // One network run. d is the RUN-cycle index (0 = layer_start cycle) at
  // which ready rises; hold keeps ready high throughout. abort_at >= 0 drops
  // transmission_start on the same cycle ready is first presented in that layer.
  task automatic run_net(input dly_t dly, input bit hold, input int abort_at);
    int exp_pre;
    int d;
    int exp_cyc;
    exp_pre = 0;
    bus.layer_ready = hold;
    bus.transmission_start = 1'b0;
    step();
    bus.transmission_start = 1'b1;
    step();
    chk("load_busy", bus.busy, 1);
    chk("load_nostart", bus.layer_start, 0);
    for (int l = 0; l < 5; l++) begin
      step();
      chk($sformatf("L%0d_start", l), bus.layer_start, 1);
      chk($sformatf("L%0d_num", l), bus.layer_num, l);
      chk($sformatf("L%0d_type", l), bus.layer_type, t_type[l]);
      chk($sformatf("L%0d_pre", l), bus.pre_layer_type, exp_pre);
      chk($sformatf("L%0d_fm_size", l), bus.fm_size, t_fm[l]);
      chk($sformatf("L%0d_fm_depth", l), bus.fm_depth, t_dep[l]);
      chk($sformatf("L%0d_fm_size_out", l), bus.fm_size_out, t_fout[l]);
      chk($sformatf("L%0d_padding", l), bus.padding_out, 0);
      chk($sformatf("L%0d_kernel_num", l), bus.kernel_num, t_kn[l]);
      chk($sformatf("L%0d_kernel_size", l), bus.kernel_size, t_ks[l]);
      chk($sformatf("L%0d_pool_type", l), bus.pool_type, 0);
      chk($sformatf("L%0d_pool_win", l), bus.pool_win_size, t_pw[l]);
      chk($sformatf("L%0d_activation", l), bus.activation, t_act[l]);
      d = hold ? 0 : dly[l];
      for (int k = 0; k < 64; k++) begin
        bus.layer_ready = hold || (k >= d);
        if (l == abort_at && k == d) bus.transmission_start = 1'b0;
        step();
        if (l == abort_at && k == d) break;
        if (k >= d && k >= 1) break;
        chk($sformatf("L%0d_run_busy", l), bus.busy, 1);
      end
      if (l == abort_at) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_num", bus.layer_num, 0);
        chk("abort_pre", bus.pre_layer_type, 0);
        chk("abort_start", bus.layer_start, 0);
        chk("abort_cfg_hold", bus.fm_size, t_fm[l]);
        bus.layer_ready = 1'b0;
        repeat (3) begin
          step();
          chk("abort_no_done", bus.net_done, 0);
          chk("abort_idle", bus.busy, 0);
        end
        return;
      end
      chk($sformatf("L%0d_adv_nostart", l), bus.layer_start, 0);
      bus.layer_ready = hold;
      step();
      exp_cyc = (d < 1) ? 1 : d;
      chk($sformatf("L%0d_cycles", l), bus.layer_cycles, exp_cyc);
      if (l == 4) begin
        chk("net_done", bus.net_done, 1);
        chk("done_busy", bus.busy, 1);
        step();
        chk("net_done_pulse", bus.net_done, 0);
        chk("after_busy", bus.busy, 0);
        chk("after_num_hold", bus.layer_num, 4);
        chk("after_cfg_hold", bus.fm_size, t_fm[4]);
      end else begin
        chk($sformatf("L%0d_load_done0", l), bus.net_done, 0);
        chk($sformatf("L%0d_load_nostart", l), bus.layer_start, 0);
      end
      exp_pre = t_type[l];
    end
  endtask

  initial begin
    dly_t dl;
    bit   hold;
    int   ab;

    bus.transmission_start = 1'b0;
    bus.layer_ready = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) step();
    rst = 1'b1;
    step();
    chk_zero("post_reset");

    // Ready 10 cycles after each layer_start.
    run_net('{10, 10, 10, 10, 10}, 1'b0, -1);

    // Start left high after completion must not restart.
    repeat (6) begin
      step();
      chk("held_no_start", bus.layer_start, 0);
      chk("held_idle", bus.busy, 0);
    end

    // Ready held high throughout.
    run_net('{0, 0, 0, 0, 0}, 1'b1, -1);

    // Abort in L2 coinciding with ready, then a clean restart.
    run_net('{3, 3, 4, 3, 3}, 1'b0, 2);
    run_net('{2, 5, 1, 7, 3}, 1'b0, -1);

    // Asynchronous reset in the middle of a RUN.
    bus.transmission_start = 1'b0;
    bus.layer_ready = 1'b0;
    step();
    bus.transmission_start = 1'b1;
    repeat (4) step();
    chk("pre_reset_busy", bus.busy, 1);
    rst = 1'b0;
    bus.transmission_start = 1'b0;
    #1;
    chk_zero("async_reset");
    step();
    chk_zero("reset_hold");
    rst = 1'b1;
    step();
    chk("reset_release_idle", bus.busy, 0);

    // Random ready delays, holds and aborts.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) dl[i] = $urandom_range(0, 12);
      hold = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_net(dl, hold, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
